apb_slave_regfile: RTL and testbench

APB completer holding a bank of NUM_REGS software-visible registers; it answers transfers issued by the team's APB master on the same PCLK/PRESETn domain. It decodes word-aligned addresses, inserts a fixed number of wait states, commits writes and returns read data with PREADY. Out-of-range or misaligned accesses complete with PSLVERR. This block is the reference target for master bring-up and system tests.

---
 rtl/apb_slave_regfile.sv | 205 ++++++++++++++++++++
 tb/tb_apb_slave_regfile.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/apb_slave_regfile.sv
// -----------------------------------------------------------------------------
// apb_slave_regfile
//
// APB completer that holds a bank of NUM_REGS word-wide software registers.
// Each transfer takes a setup cycle, an optional fixed number of wait states,
// and a final access cycle in which S_PREADY is high.
//
// Addresses are byte addresses. The register index is S_PADDR[ADDRESS_WIDTH-1:2].
// A transfer completes with S_PSLVERR when the address is misaligned or when
// the index is outside the register bank. Writes to such an address are dropped.
//
// Optional feature macro: APB_SLV_WAIT_EN
//   defined   : a wait counter and the WAIT state are built in, and
//               WAIT_CYCLES wait states are inserted into every transfer.
//   undefined : every transfer takes two cycles and WAIT_CYCLES is ignored.
//
// Ports
//   PCLK       in   clock; all logic runs on the rising edge
//   PRESETn    in   asynchronous active-low reset
//   S_PSEL     in   slave select
//   S_PENABLE  in   access phase indicator
//   S_PWRITE   in   1 = write, 0 = read
//   S_PADDR    in   byte address [ADDRESS_WIDTH]
//   S_PWDATA   in   write data [DATA_WIDTH]
//   S_PRDATA   out  read data, valid while S_PREADY=1 on a read [DATA_WIDTH]
//   S_PREADY   out  transfer completion (registered)
//   S_PSLVERR  out  error response, valid while S_PREADY=1 (registered)
// -----------------------------------------------------------------------------
module apb_slave_regfile #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int NUM_REGS      = 16,
  parameter int WAIT_CYCLES   = 2
) (
  input  logic                     PCLK,
  input  logic                     PRESETn,
  input  logic                     S_PSEL,
  input  logic                     S_PENABLE,
  input  logic                     S_PWRITE,
  input  logic [ADDRESS_WIDTH-1:0] S_PADDR,
  input  logic [DATA_WIDTH-1:0]    S_PWDATA,
  output logic [DATA_WIDTH-1:0]    S_PRDATA,
  output logic                     S_PREADY,
  output logic                     S_PSLVERR
);

  localparam int IDX_W = ADDRESS_WIDTH - 2;
  localparam int SEL_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

`ifdef APB_SLV_WAIT_EN
  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, READY = 2'd2} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, READY = 2'd2} state_t;
`endif

  state_t                  state_reg, state_next;
  logic                    write_reg, write_next;
  logic                    err_reg, err_next;
  logic [SEL_W-1:0]        sel_reg, sel_next;
  logic [DATA_WIDTH-1:0]   rlat_reg, rlat_next;
  logic [DATA_WIDTH-1:0]   prdata_reg, prdata_next;
  logic                    pready_reg, pready_next;
  logic                    pslverr_reg, pslverr_next;
  logic                    commit_we;
  logic [NUM_REGS-1:0]     reg_we;
  logic [DATA_WIDTH-1:0]   regs_reg [NUM_REGS];

`ifdef APB_SLV_WAIT_EN
  logic [3:0]              cnt_reg, cnt_next;
`else
  // WAIT_CYCLES has no effect in this build; the parameter stays so both
  // builds share one instantiation interface.
  logic [3:0]              unused_wait_cycles;
  assign unused_wait_cycles = 4'(WAIT_CYCLES);
`endif

  // Decode of the live bus address. This is used only on the setup edge;
  // everything after that works from the latched copies.
  logic [IDX_W-1:0]        live_idx;
  logic [SEL_W-1:0]        live_sel;
  logic                    live_err;
  logic [DATA_WIDTH-1:0]   live_rdata;

  assign live_idx   = S_PADDR[ADDRESS_WIDTH-1:2];
  assign live_sel   = live_idx[SEL_W-1:0];
  assign live_err   = (S_PADDR[1:0] != 2'b00) || (live_idx >= IDX_W'(NUM_REGS));
  // live_sel can point past the bank only when live_err is set, so the
  // array access is masked in that case.
  assign live_rdata = live_err ? '0 : regs_reg[live_sel];

  // One write strobe per register, which is selected by the latched index.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_we
      assign reg_we[gi] = commit_we && (sel_reg == SEL_W'(gi));
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    write_next = write_reg;
    err_next   = err_reg;
    sel_next   = sel_reg;
    rlat_next  = rlat_reg;
    commit_we  = 1'b0;
`ifdef APB_SLV_WAIT_EN
    cnt_next   = cnt_reg;
`endif
    case (state_reg)
      IDLE: begin
        // Only a real setup phase starts a transfer. PSEL together with
        // PENABLE and no preceding setup is ignored.
        if (S_PSEL && !S_PENABLE) begin
          write_next = S_PWRITE;
          err_next   = live_err;
          sel_next   = live_sel;
          rlat_next  = live_rdata;
`ifdef APB_SLV_WAIT_EN
          cnt_next   = 4'(WAIT_CYCLES);
          state_next = (WAIT_CYCLES != 0) ? WAIT : READY;
`else
          state_next = READY;
`endif
        end
      end
`ifdef APB_SLV_WAIT_EN
      WAIT: begin
        if (!S_PSEL) begin
          cnt_next   = 4'd0;
          state_next = IDLE;
        end else if (cnt_reg <= 4'd1) begin
          cnt_next   = 4'd0;
          state_next = READY;
        end else begin
          cnt_next   = cnt_reg - 4'd1;
        end
      end
`endif
      READY: begin
        if (!S_PSEL) begin
          state_next = IDLE;
        end else if (S_PENABLE) begin
          commit_we  = write_reg && !err_reg;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase

    // The outputs are registered from the next state, so they are already
    // valid in the first cycle spent in READY.
    pready_next  = (state_next == READY);
    pslverr_next = (state_next == READY) && err_next;
    prdata_next  = ((state_next == READY) && !write_next) ? rlat_next : '0;
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_reg   <= IDLE;
      write_reg   <= 1'b0;
      err_reg     <= 1'b0;
      sel_reg     <= '0;
      rlat_reg    <= '0;
      prdata_reg  <= '0;
      pready_reg  <= 1'b0;
      pslverr_reg <= 1'b0;
`ifdef APB_SLV_WAIT_EN
      cnt_reg     <= 4'd0;
`endif
    end else begin
      state_reg   <= state_next;
      write_reg   <= write_next;
      err_reg     <= err_next;
      sel_reg     <= sel_next;
      rlat_reg    <= rlat_next;
      prdata_reg  <= prdata_next;
      pready_reg  <= pready_next;
      pslverr_reg <= pslverr_next;
`ifdef APB_SLV_WAIT_EN
      cnt_reg     <= cnt_next;
`endif
    end
  end

  // The register bank is cleared by reset, so it is built from flops and not
  // from RAM. A register changes only on a completing, error-free write.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_reg[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (reg_we[i]) begin
          regs_reg[i] <= S_PWDATA;
        end
      end
    end
  end

  assign S_PRDATA  = prdata_reg;
  assign S_PREADY  = pready_reg;
  assign S_PSLVERR = pslverr_reg;

endmodule

// File: tb/tb_apb_slave_regfile.sv
// -----------------------------------------------------------------------------
// tb_apb_slave_regfile
//
// Acts as the APB master for apb_slave_regfile. A table of transfers holds the
// expected read data and error flag for each entry. The expected response,
// including the expected access-cycle count, goes into a scoreboard queue
// when the setup phase is driven. It is popped and compared when S_PREADY is
// seen. Hand-written sequences cover the ignored no-setup access, the abort,
// and reset in the middle of a transfer.
// -----------------------------------------------------------------------------
module tb_apb_slave_regfile;

`ifdef APB_SLV_WAIT_EN
  localparam int EXP_WAITS = 2;
`else
  localparam int EXP_WAITS = 0;
`endif

  logic        PCLK = 1'b0;
  logic        PRESETn = 1'b1;
  logic        psel = 1'b0;
  logic        pen = 1'b0;
  logic        pwrite = 1'b0;
  logic [31:0] paddr = '0;
  logic [31:0] pwdata = '0;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  always #5 PCLK = ~PCLK;

  apb_slave_regfile #(
    .ADDRESS_WIDTH(32),
    .DATA_WIDTH(32),
    .NUM_REGS(16),
    .WAIT_CYCLES(2)
  ) dut (
    .PCLK(PCLK),
    .PRESETn(PRESETn),
    .S_PSEL(psel),
    .S_PENABLE(pen),
    .S_PWRITE(pwrite),
    .S_PADDR(paddr),
    .S_PWDATA(pwdata),
    .S_PRDATA(prdata),
    .S_PREADY(pready),
    .S_PSLVERR(pslverr)
  );

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    bit          exp_err;
  } vec_t;

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] rdata;
    bit          err;
    int          cycles;
  } exp_t;

  vec_t vecs[$];
  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic void add_vec(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                                  input logic [31:0] exp_rdata, input bit exp_err);
    vec_t v;
    v.wr = wr; v.addr = addr; v.wdata = wdata; v.exp_rdata = exp_rdata; v.exp_err = exp_err;
    vecs.push_back(v);
  endfunction

  // A full transfer. The setup phase is driven on a falling edge. The task
  // returns on the falling edge where S_PREADY is seen, so the completing
  // rising edge comes next and a following call runs back-to-back.
  task automatic apb_xfer(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] exp_rdata, input bit exp_err);
    exp_t e;
    exp_t got;
    int   cyc;
    @(negedge PCLK);
    psel = 1'b1; pen = 1'b0; pwrite = wr; paddr = addr; pwdata = wdata;
    e.wr = wr; e.addr = addr; e.rdata = exp_rdata; e.err = exp_err; e.cycles = EXP_WAITS + 1;
    sb_q.push_back(e);
    @(negedge PCLK);
    pen = 1'b1;
    cyc = 1;
    while (pready !== 1'b1 && cyc < 40) begin
      @(negedge PCLK);
      cyc++;
    end
    got = sb_q.pop_front();
    check("access_cycles", cyc, got.cycles);
    check(got.wr ? "wr_prdata" : "rd_prdata", prdata, got.wr ? 32'h0 : got.rdata);
    check("pslverr", {31'd0, pslverr}, {31'd0, got.err});
    $display("xfer %s addr=%h wdata=%h prdata=%h pslverr=%0d cycles=%0d",
             wr ? "WR" : "RD", addr, wdata, prdata, pslverr, cyc + 1);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge PCLK);
      psel = 1'b0; pen = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;

    // Reset with PRESETn low for three cycles, checking the outputs each cycle.
    #2 PRESETn = 1'b0;
    repeat (3) begin
      @(negedge PCLK);
      check("rst_pready", {31'd0, pready}, 32'h0);
      check("rst_pslverr", {31'd0, pslverr}, 32'h0);
      check("rst_prdata", prdata, 32'h0);
    end
    PRESETn = 1'b1;
    idle(1);

    // Table of transfers, applied back-to-back with no idle cycles between them.
    for (int i = 0; i < 16; i++) add_vec(1'b0, 32'(i * 4), 32'h0, 32'h0, 1'b0);
    add_vec(1'b1, 32'h0C, 32'hDEADBEEF, 32'h0, 1'b0);
    add_vec(1'b0, 32'h0C, 32'h0,        32'hDEADBEEF, 1'b0);
    add_vec(1'b1, 32'h40, 32'h12345678, 32'h0, 1'b1);
    add_vec(1'b1, 32'h06, 32'h12345678, 32'h0, 1'b1);
    add_vec(1'b0, 32'h00, 32'h0,        32'h0, 1'b0);
    add_vec(1'b0, 32'h04, 32'h0,        32'h0, 1'b0);
    add_vec(1'b1, 32'h00, 32'h1,        32'h0, 1'b0);
    add_vec(1'b1, 32'h04, 32'h2,        32'h0, 1'b0);
    add_vec(1'b0, 32'h00, 32'h0,        32'h1, 1'b0);
    add_vec(1'b0, 32'h04, 32'h0,        32'h2, 1'b0);
    add_vec(1'b1, 32'h3C, 32'hCAFEF00D, 32'h0, 1'b0);
    add_vec(1'b0, 32'h3C, 32'h0,        32'hCAFEF00D, 1'b0);
    add_vec(1'b0, 32'h40, 32'h0,        32'h0, 1'b1);
    add_vec(1'b0, 32'h3E, 32'h0,        32'h0, 1'b1);
    add_vec(1'b0, 32'hFFFFFFFC, 32'h0,  32'h0, 1'b1);
    add_vec(1'b0, 32'h0C, 32'h0,        32'hDEADBEEF, 1'b0);
    foreach (vecs[i]) apb_xfer(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rdata, vecs[i].exp_err);
    idle(2);

    // PSEL and PENABLE asserted in IDLE with no setup phase must be ignored.
    @(negedge PCLK);
    psel = 1'b1; pen = 1'b1; pwrite = 1'b1; paddr = 32'h08; pwdata = 32'h00000BAD;
    repeat (3) begin
      @(negedge PCLK);
      check("nosetup_pready", {31'd0, pready}, 32'h0);
    end
    idle(1);
    apb_xfer(1'b0, 32'h08, 32'h0, 32'h0, 1'b0);
    idle(1);

    // Drop PSEL right after the setup phase. The transfer aborts and no write happens.
    @(negedge PCLK);
    psel = 1'b1; pen = 1'b0; pwrite = 1'b1; paddr = 32'h08; pwdata = 32'hAAAA5555;
    @(negedge PCLK);
    psel = 1'b0; pen = 1'b0;
    @(negedge PCLK);
    check("abort_pready", {31'd0, pready}, 32'h0);
    check("abort_pslverr", {31'd0, pslverr}, 32'h0);
    $display("xfer ABORT addr=%h wdata=%h", 32'h08, 32'hAAAA5555);
    apb_xfer(1'b0, 32'h08, 32'h0, 32'h0, 1'b0);
    idle(1);

    // Reset while a read is presenting data. The outputs clear at once.
    @(negedge PCLK);
    psel = 1'b1; pen = 1'b0; pwrite = 1'b0; paddr = 32'h0C;
    @(negedge PCLK);
    pen = 1'b1;
    cyc = 1;
    while (pready !== 1'b1 && cyc < 40) begin
      @(negedge PCLK);
      cyc++;
    end
    check("rstrd_cycles", cyc, EXP_WAITS + 1);
    check("rstrd_prdata", prdata, 32'hDEADBEEF);
    #2 PRESETn = 1'b0; psel = 1'b0; pen = 1'b0;
    #1;
    check("rstrd_pready_now", {31'd0, pready}, 32'h0);
    check("rstrd_prdata_now", prdata, 32'h0);
    $display("xfer RD-RESET addr=%h", 32'h0C);
    @(negedge PCLK);
    PRESETn = 1'b1;

    // Reset in the first access cycle of a write. The write is lost.
    @(negedge PCLK);
    psel = 1'b1; pen = 1'b0; pwrite = 1'b1; paddr = 32'h10; pwdata = 32'h00000077;
    @(negedge PCLK);
    pen = 1'b1;
    #2 PRESETn = 1'b0; psel = 1'b0; pen = 1'b0;
    #1;
    check("rstwr_pready_now", {31'd0, pready}, 32'h0);
    check("rstwr_pslverr_now", {31'd0, pslverr}, 32'h0);
    $display("xfer WR-RESET addr=%h wdata=%h", 32'h10, 32'h77);
    repeat (2) @(negedge PCLK);
    PRESETn = 1'b1;

    // After reset every register reads back as zero.
    apb_xfer(1'b0, 32'h10, 32'h0, 32'h0, 1'b0);
    apb_xfer(1'b0, 32'h0C, 32'h0, 32'h0, 1'b0);
    apb_xfer(1'b0, 32'h3C, 32'h0, 32'h0, 1'b0);
    apb_xfer(1'b0, 32'h00, 32'h0, 32'h0, 1'b0);
    idle(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
